// File: rtl/multi_edge_detector.sv
// Purpose : per-channel synchronised edge detector with sticky flags and a saturating event counter.
// Latency : a d change first sampled at edge N shows on pulse/any_edge after edge N+SYNC_STAGES.
// Backpr. : none; free-running, every qualified event is registered the cycle it is seen.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous active-low reset, dominates clr and all events
//   d         - asynchronous channel inputs, one bit per channel
//   mode      - per-channel qualifier, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 either
//   clr       - synchronous clear of sticky flags and edge_cnt (same-cycle events still land)
//   pulse     - one-cycle registered strobe per channel
//   sticky    - per-channel latched event flag
//   any_edge  - registered OR of the pulse vector
//   edge_cnt  - saturating count of all qualified events
module multi_edge_detector #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   d,
  input  logic [2*WIDTH-1:0] mode,
  input  logic               clr,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic               any_edge,
  output logic [CNT_W-1:0]   edge_cnt
);

  // Events are held off until the synchroniser and prev flop carry only
  // post-reset samples, so a level already high at release is not an edge.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  // Sum width leaves headroom for counter + a full popcount before saturating.
  localparam int                SUM_W   = CNT_W + 7;
  localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  prev_q;
  logic [ARM_W-1:0]                  arm_cnt;
  logic                              armed;

  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] ev;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;

  assign s      = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_cnt == ARM_W'(ARM_MAX));
  assign rise_v = s & ~prev_q;
  assign fall_v = ~s & prev_q;

  // Mode is applied here, on the edge comparison itself, so changing mode
  // alone can never manufacture an event.
  always_comb begin
    ev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ev[i] = (mode[2*i] & rise_v[i]) | (mode[2*i+1] & fall_v[i]);
    end
    ev = ev & {WIDTH{armed}};
  end

  // A clear restarts the count from this cycle's events rather than from zero.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SUM_W'(ev[i]);
    end
    sum     = (clr ? '0 : SUM_W'(edge_cnt)) + pop;
    cnt_nxt = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= '0;
      arm_cnt  <= '0;
      pulse    <= '0;
      sticky   <= '0;
      any_edge <= 1'b0;
      edge_cnt <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q   <= s;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
      pulse    <= ev;
      any_edge <= |ev;
      // An event in the clearing cycle wins over the clear.
      sticky   <= (clr ? '0 : sticky) | ev;
      edge_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Purpose : randomized + directed bench for multi_edge_detector against a sample-history model.
// Latency : checks every cycle at the falling edge, after the DUT has updated.
// Backpr. : n/a.
module tb_multi_edge_detector;

  localparam int W     = 4;
  localparam int S     = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    d;
  logic [2*W-1:0]  mode;
  logic            clr;
  logic [W-1:0]    pulse;
  logic [W-1:0]    sticky;
  logic            any_edge;
  logic [CW-1:0]   edge_cnt;

  multi_edge_detector #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .mode     (mode),
    .clr      (clr),
    .pulse    (pulse),
    .sticky   (sticky),
    .any_edge (any_edge),
    .edge_cnt (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the list of d values sampled at each edge since reset
  // release. An event at edge j compares the samples taken S and S+1 edges
  // earlier, and only once both of those are post-reset samples.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_pulse;
  logic [W-1:0] m_sticky;
  logic         m_any;
  int           m_cnt;

  task automatic model_update();
    int j;
    int n;
    logic [W-1:0] cur, old, ev;
    logic [1:0] m;
    logic r, f;
    if (!rst_n) begin
      hist.delete();
      m_pulse  = '0;
      m_sticky = '0;
      m_any    = 1'b0;
      m_cnt    = 0;
    end else begin
      j = hist.size();
      hist.push_back(d);
      ev = '0;
      if (j >= S + 1) begin
        cur = hist[j-S];
        old = hist[j-S-1];
        for (int i = 0; i < W; i++) begin
          m = mode[2*i +: 2];
          r = cur[i] && !old[i];
          f = !cur[i] && old[i];
          if ((m == 2'b01 && r) || (m == 2'b10 && f) || (m == 2'b11 && (r || f)))
            ev[i] = 1'b1;
        end
      end
      n = 0;
      for (int i = 0; i < W; i++) n += int'(ev[i]);
      m_pulse  = ev;
      m_any    = (ev != '0);
      m_sticky = clr ? ev : (m_sticky | ev);
      m_cnt    = clr ? n : m_cnt + n;
      if (m_cnt > CMAX) m_cnt = CMAX;
    end
  endtask

  // One clock: model follows the inputs at the rising edge, DUT outputs
  // are compared at the falling edge; callers change inputs afterwards.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_eq("pulse",    int'(pulse),    int'(m_pulse));
    check_eq("any_edge", int'(any_edge), int'(m_any));
    check_eq("sticky",   int'(sticky),   int'(m_sticky));
    check_eq("edge_cnt", int'(edge_cnt), m_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    d     = '0;
    mode  = 8'hFF;
    clr   = 1'b0;
    repeat (3) step();
    check_eq("rst_cnt", int'(edge_cnt), 0);
    check_eq("rst_pulse", int'(pulse), 0);

    // Single rising edge on ch0, all channels in either-edge mode.
    rst_n = 1'b1;
    repeat (6) step();
    d = 4'b0001;
    step();
    step();
    check_eq("r026_early", int'(pulse), 0);
    step();
    check_eq("r026_pulse",  int'(pulse),    1);
    check_eq("r026_any",    int'(any_edge), 1);
    check_eq("r026_sticky", int'(sticky),   1);
    check_eq("r026_cnt",    int'(edge_cnt), 1);
    step();
    check_eq("r026_once", int'(pulse), 0);

    // ch0 rise-only, ch1 fall-only, others off.
    mode = 8'b0000_1001;
    d    = 4'b0000;
    repeat (4) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("r027_clr_cnt", int'(edge_cnt), 0);
    d = 4'b0011;
    repeat (4) step();
    check_eq("r027_rise_sticky", int'(sticky), 4'b0001);
    d = 4'b0000;
    repeat (4) step();
    check_eq("r027_sticky", int'(sticky),   4'b0011);
    check_eq("r027_cnt",    int'(edge_cnt), 2);

    // All four channels toggle with clr landing on the event cycle.
    mode = 8'hFF;
    d    = 4'b1111;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("r029_pulse",  int'(pulse),    4'b1111);
    check_eq("r029_sticky", int'(sticky),   4'b1111);
    check_eq("r029_cnt",    int'(edge_cnt), 4);
    d = 4'b0000;
    repeat (4) step();

    // Saturation: 20 edges on ch0 into a 4-bit counter.
    mode = 8'b0000_0011;
    clr  = 1'b1;
    step();
    clr  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      d[0] = ~d[0];
      step();
      step();
    end
    repeat (3) step();
    check_eq("r030_sat", int'(edge_cnt), CMAX);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("r030_clr", int'(edge_cnt), 0);

    // Inputs high through reset release must not register as edges.
    mode  = 8'hFF;
    d     = 4'b1111;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) begin
      step();
      check_eq("r028_pulse", int'(pulse), 0);
    end
    check_eq("r028_sticky", int'(sticky),   0);
    check_eq("r028_cnt",    int'(edge_cnt), 0);

    // Reset pulse right after d[2] rises discards the in-flight edge.
    d = 4'b0000;
    repeat (5) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    d = 4'b0100;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) begin
      step();
      check_eq("r031_pulse2", int'(pulse[2]), 0);
    end
    check_eq("r031_sticky", int'(sticky),   0);
    check_eq("r031_any",    int'(any_edge), 0);
    check_eq("r031_cnt",    int'(edge_cnt), 0);

    // Random traffic: bit flips, mode changes, clears and occasional resets.
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 3) == 0) d[i] = ~d[i];
      end
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      clr = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
